// File: rtl/mode_request_encoder.sv
// Synchronizes and debounces one-hot mode request lines, then presents the
// encoded mode to the counter with a valid/ack handshake.
module mode_request_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [7:0] Req,
    input  logic       Ack,
    output logic [2:0] Mode,
    output logic       Mode_valid,
    output logic       Multi_err,
    output logic       Busy
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_HOLD         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_e;

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    // Highest set bit wins, so bit 7 has top priority.
    function automatic logic [2:0] highest_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = vec[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic more_than_one(input logic [7:0] vec);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, vec[i]};
        end
        return (cnt > 4'd1);
    endfunction

    state_e     state_q, state_d;
    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] count_q, count_d;
    logic [2:0] mode_q, mode_d;
    logic       multi_err_q, multi_err_d;
    logic       mode_valid_q, mode_valid_d;

    // Next-state and output-register logic; sync2_q is the only view of Req.
    always_comb begin
        state_d      = state_q;
        sync1_d      = Req;
        sync2_d      = sync1_q;
        cap_d        = cap_q;
        count_d      = count_q;
        mode_d       = mode_q;
        multi_err_d  = multi_err_q;
        mode_valid_d = mode_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q != 8'h00) begin
                    state_d = ST_DEBOUNCE;
                    cap_d   = sync2_q;
                    count_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (sync2_q == 8'h00) begin
                    state_d = ST_IDLE;
                end else if (sync2_q != cap_q) begin
                    cap_d   = sync2_q;
                    count_d = 8'd0;
                end else if (count_q == CNT_MAX) begin
                    state_d      = ST_HOLD;
                    mode_d       = highest_index(cap_q);
                    multi_err_d  = more_than_one(cap_q);
                    mode_valid_d = 1'b1;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (Ack) begin
                    mode_valid_d = 1'b0;
                    state_d      = ST_WAIT_RELEASE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT_RELEASE: begin
                // A request still held after the handshake must not re-encode.
                if (sync2_q == 8'h00) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                count_d      = 8'd0;
                mode_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; Reset overrides every other input.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 8'h00;
            sync2_q      <= 8'h00;
            cap_q        <= 8'h00;
            count_q      <= 8'd0;
            mode_q       <= 3'b000;
            multi_err_q  <= 1'b0;
            mode_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cap_q        <= cap_d;
            count_q      <= count_d;
            mode_q       <= mode_d;
            multi_err_q  <= multi_err_d;
            mode_valid_q <= mode_valid_d;
        end
    end

    assign Mode       = mode_q;
    assign Mode_valid = mode_valid_q;
    assign Multi_err  = multi_err_q;
    assign Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mode_request_encoder.sv
// Bench for mode_request_encoder: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the request handshake.
module tb_mode_request_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] Req;
    logic       Ack;
    logic [2:0] Mode;
    logic       Mode_valid;
    logic       Multi_err;
    logic       Busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mode_request_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Req       (Req),
        .Ack       (Ack),
        .Mode      (Mode),
        .Mode_valid(Mode_valid),
        .Multi_err (Multi_err),
        .Busy      (Busy)
    );

    // Behavioural model: two-sample delay line, then "debouncing / presented /
    // awaiting release" activities tracked as independent flags.
    logic [7:0] m_s1, m_s2, m_cap;
    int         m_matches;
    bit         m_debouncing, m_presented, m_awaiting_release;
    logic [2:0] m_mode;
    bit         m_multi, m_valid;
    int         valid_rises;
    logic       prev_valid;

    function automatic logic [2:0] top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_edge(input logic [7:0] r, input logic a, input logic rst);
        logic [7:0] s;
        if (rst) begin
            m_s1 = 8'h00; m_s2 = 8'h00; m_cap = 8'h00; m_matches = 0;
            m_debouncing = 0; m_presented = 0; m_awaiting_release = 0;
            m_mode = 3'd0; m_multi = 0; m_valid = 0;
        end else begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = r;
            if (m_presented) begin
                if (a) begin
                    m_presented = 0; m_valid = 0; m_awaiting_release = 1;
                end
            end else if (m_awaiting_release) begin
                if (s == 8'h00) m_awaiting_release = 0;
            end else if (m_debouncing) begin
                if (s == 8'h00) begin
                    m_debouncing = 0;
                end else if (s != m_cap) begin
                    m_cap = s; m_matches = 0;
                end else begin
                    m_matches++;
                    if (m_matches == D) begin
                        m_debouncing = 0; m_presented = 1; m_valid = 1;
                        m_mode  = top_bit(m_cap);
                        m_multi = ($countones(m_cap) > 1);
                    end
                end
            end else if (s != 8'h00) begin
                m_debouncing = 1; m_cap = s; m_matches = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input logic [7:0] r, input logic a, input logic rst);
        Req = r; Ack = a; Reset = rst;
        @(posedge clk);
        model_edge(r, a, rst);
        #1;
        chk("mode",       32'(Mode),       32'(m_mode));
        chk("mode_valid", 32'(Mode_valid), 32'(m_valid));
        chk("multi_err",  32'(Multi_err),  32'(m_multi));
        chk("busy",       32'(Busy),       32'(m_debouncing | m_presented | m_awaiting_release));
        if (Mode_valid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
        prev_valid = Mode_valid;
    endtask

    initial begin
        int first;
        logic [7:0] r;
        logic       a, rst;
        Req = 8'h00; Ack = 1'b0; Reset = 1'b1;
        prev_valid = 1'b0; valid_rises = 0;
        model_edge(8'h00, 1'b0, 1'b1);

        // Reset state
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);

        // Single clean request: latency D+3 edges, Mode 3
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step(8'h08, 1'b0, 1'b0);
            if (Mode_valid === 1'b1 && first == 0) first = i;
        end
        chk("latency_edge", 32'(first), 32'(D + 3));
        chk("single_mode", 32'(Mode), 32'd3);
        step(8'h08, 1'b1, 1'b0);
        chk("ack_clears_valid", 32'(Mode_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);

        // Bounce then settle: exactly one encode of Mode 2
        valid_rises = 0;
        for (int i = 0; i < 10; i++) step(((i / 2) % 2 == 0) ? 8'h04 : 8'h00, 1'b0, 1'b0);
        chk("bounce_no_early", 32'(valid_rises), 32'd0);
        for (int i = 0; i < 12; i++) step(8'h04, 1'b0, 1'b0);
        chk("bounce_one_valid", 32'(valid_rises), 32'd1);
        chk("bounce_mode", 32'(Mode), 32'd2);
        step(8'h04, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);

        // Multiple bits set
        for (int i = 0; i < 10; i++) step(8'h41, 1'b0, 1'b0);
        chk("multi_mode", 32'(Mode), 32'd6);
        chk("multi_err_set", 32'(Multi_err), 32'd1);
        step(8'h41, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);
        chk("retain_after_ack", 32'(Mode), 32'd6);

        // Long-held request: one handshake, then wait for release
        valid_rises = 0;
        for (int i = 0; i < 50; i++) step(8'h01, (i == 12) ? 1'b1 : 1'b0, 1'b0);
        chk("held_one_handshake", 32'(valid_rises), 32'd1);
        chk("held_busy", 32'(Busy), 32'd1);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0);
        chk("held_released_idle", 32'(Busy), 32'd0);

        // Change during HOLD is ignored; re-encode only after release
        valid_rises = 0;
        for (int i = 0; i < 8; i++) step(8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(8'h02, 1'b0, 1'b0);
        chk("hold_mode_kept", 32'(Mode), 32'd5);
        step(8'h02, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(8'h02, 1'b0, 1'b0);
        chk("hold_no_reencode", 32'(valid_rises), 32'd1);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(8'h02, 1'b0, 1'b0);
        chk("new_request_mode", 32'(Mode), 32'd1);
        step(8'h02, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);

        // Reset mid-HOLD with the request still held
        for (int i = 0; i < 8; i++) step(8'h10, 1'b0, 1'b0);
        step(8'h10, 1'b0, 1'b1);
        chk("rst_valid_low", 32'(Mode_valid), 32'd0);
        chk("rst_mode_zero", 32'(Mode), 32'd0);
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            step(8'h10, 1'b0, 1'b0);
            if (Mode_valid === 1'b1 && first == 0) first = i;
        end
        chk("rst_reencode_edge", 32'(first), 32'(D + 3));
        step(8'h10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);

        // Random traffic: sticky requests, random Ack, rare Reset
        r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 15) begin
                case ($urandom_range(0, 2))
                    0:       r = 8'h00;
                    1:       r = 8'(8'h01 << $urandom_range(0, 7));
                    default: r = 8'($urandom);
                endcase
            end
            a   = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step(r, a, rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mode_request_encoder.md
MODE_REQUEST_ENCODER -- requirements
Module: mode_request_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, range 1..255: consecutive cycles the synchronized request vector must stay unchanged before it is encoded.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Req  input  8  asynchronous one-hot mode request lines (bit n = mode n); may bounce.
REQ-005 Ack  input  1  counter accepts the presented Mode; sampled only in HOLD.
REQ-006 Mode  output  3  registered encoded mode; drives the counter's 3-bit mode-select input.
REQ-007 Mode_valid  output  1  registered; high while a new Mode awaits Ack.
REQ-008 Multi_err  output  1  registered; high when the last encoded vector had more than one bit set.
REQ-009 Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 Req shall pass through a two-flop synchronizer; all downstream logic uses only the second-stage vector S.
REQ-011 FSM states: IDLE, DEBOUNCE, HOLD, WAIT_RELEASE; encoded in 2 bits; unused encodings return to IDLE.
REQ-012 IDLE: S != 0 -> DEBOUNCE, capture S into CAP, count = 0; otherwise remain in IDLE.
REQ-013 DEBOUNCE, S == 0: -> IDLE.
REQ-014 DEBOUNCE, S != CAP and S != 0: CAP = S, count = 0, remain in DEBOUNCE (restart).
REQ-015 DEBOUNCE, S == CAP and count < DEBOUNCE_CYCLES-1: count + 1.
REQ-016 DEBOUNCE, S == CAP and count == DEBOUNCE_CYCLES-1: -> HOLD; same edge loads Mode, Multi_err and Mode_valid = 1.
REQ-017 Encoding: Mode = index of the highest set bit of CAP (bit 7 highest priority); Multi_err = 1 when popcount(CAP) > 1, else 0.
REQ-018 Latency: with Req stable ahead of rising edge 1, Mode_valid shall first be high after rising edge DEBOUNCE_CYCLES+3; edge 7 for the default.
REQ-019 HOLD: Mode, Multi_err and Mode_valid hold; changes on S are ignored.
REQ-020 HOLD, Ack = 1 at a rising edge: Mode_valid = 0 and -> WAIT_RELEASE on that edge.
REQ-021 Ack outside HOLD shall have no effect.
REQ-022 WAIT_RELEASE: remain until S == 0, then -> IDLE; a held request shall never be encoded twice.
REQ-023 Mode and Multi_err shall retain their last encoded values after the handshake until the next encode.
REQ-024 Busy = (state != IDLE), combinational from the state register.
REQ-025 Count register width 8 bits; it never exceeds DEBOUNCE_CYCLES-1 and never wraps.

Reset
REQ-026 Reset = 1 at a rising edge, in any state: state = IDLE, count = 0, CAP = 0, synchronizer flops = 0, Mode = 3'b000, Mode_valid = 0, Multi_err = 0.
REQ-027 Reset has priority over every other input on the same edge.
REQ-028 Reset asserted mid-DEBOUNCE or mid-HOLD shall discard the pending request; a request still held after Reset releases shall be re-synchronized and re-debounced from count 0.

Verification
REQ-029 Single request: Req = 8'h08 held clean, DEBOUNCE_CYCLES = 4 -> Mode_valid rises after edge 7, Mode = 3; Multi_err = 0; Ack pulse -> Mode_valid low on that edge.
REQ-030 Bounce: Req toggles 8'h04/8'h00 every 2 cycles for 10 cycles, then holds 8'h04 -> exactly one Mode_valid, Mode = 2; no earlier assertion.
REQ-031 Multiple bits: Req = 8'h41 stable -> Mode = 6, Multi_err = 1.
REQ-032 Held request: Req = 8'h01 held for 50 cycles, Ack returned once -> one handshake only; FSM stays in WAIT_RELEASE until Req = 0, then Busy = 0.
REQ-033 Change during HOLD: Mode = 5 presented, Req switched to 8'h02 before Ack -> Mode stays 5 until Ack; no second encode until Req = 0 and a new request arrives.
REQ-034 Reset mid-HOLD: Reset = 1 for 1 cycle while Mode_valid = 1 -> next edge Mode = 0, Mode_valid = 0, Multi_err = 0, Busy = 0; a still-held Req re-encodes after a further DEBOUNCE_CYCLES+3 edges.
